// File: rtl/frame_tick_gen.sv
// Frame-rate tick generator: detects VGA vertical-sync edges and divides them per channel.
// Define VS_SYNC_EN to pass VGA_VS through a 2-flop synchronizer (VS from another clock domain).
module frame_tick_gen #(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 8,
  parameter int FRAME_W  = 16,
  parameter int EDGE_POL = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    VGA_VS,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic [NUM_CH-1:0]       frame_tick,
  output logic [NUM_CH-1:0]       frame_clk,
  output logic [FRAME_W-1:0]      frame_cnt
);

  logic vs_s;

`ifdef VS_SYNC_EN
  // Arming waits until the synchronizer has filled, so an already-active VS at release is masked.
  localparam logic [1:0] ARM_DLY = 2'd3;
  logic [1:0] vs_sync;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_sync <= '0;
    end else begin
      vs_sync <= {vs_sync[0], VGA_VS};
    end
  end

  assign vs_s = vs_sync[1];
`else
  localparam logic [1:0] ARM_DLY = 2'd1;

  assign vs_s = VGA_VS;
`endif

  logic       hist;
  logic [1:0] arm_cnt;
  logic       armed;
  logic       edge_det;
  logic       edge_r;

  assign armed = (arm_cnt == ARM_DLY);

  always_comb begin
    edge_det = 1'b0;
    if (EDGE_POL != 0) begin
      edge_det = armed & hist & ~vs_s;
    end else begin
      edge_det = armed & vs_s & ~hist;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hist      <= 1'b0;
      arm_cnt   <= '0;
      edge_r    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      hist   <= vs_s;
      edge_r <= edge_det;
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
      if (edge_det) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Terminal count per channel; a divisor of 0 behaves as 1.
  logic [NUM_CH-1:0][DIV_W-1:0] lim;
  logic [NUM_CH-1:0][DIV_W-1:0] ch_cnt;

  always_comb begin
    lim = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (div_i[k*DIV_W +: DIV_W] == '0) begin
        lim[k] = '0;
      end else begin
        lim[k] = div_i[k*DIV_W +: DIV_W] - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ch_cnt     <= '0;
      frame_tick <= '0;
      frame_clk  <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (!ch_en[k]) begin
          ch_cnt[k]     <= '0;
          frame_tick[k] <= 1'b0;
        end else if (edge_r) begin
          // >= rather than == so a divisor lowered mid-count fires instead of wrapping.
          if (ch_cnt[k] >= lim[k]) begin
            ch_cnt[k]     <= '0;
            frame_tick[k] <= 1'b1;
            frame_clk[k]  <= ~frame_clk[k];
          end else begin
            ch_cnt[k]     <= ch_cnt[k] + 1'b1;
            frame_tick[k] <= 1'b0;
          end
        end else begin
          frame_tick[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_tick_gen.sv
// Scoreboard bench for frame_tick_gen: each VS pulse queues its expected frame_cnt/tick/clk,
// a monitor pops and compares whenever frame_cnt moves.
module tb_frame_tick_gen;
  localparam int NUM_CH  = 2;
  localparam int DIV_W   = 8;
  localparam int FRAME_W = 4;
`ifdef VS_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic                    Clk = 1'b0;
  logic                    Reset = 1'b1;
  logic                    VGA_VS = 1'b1;
  logic [NUM_CH-1:0]       ch_en = '0;
  logic [NUM_CH*DIV_W-1:0] div_i = '0;
  logic [NUM_CH-1:0]       frame_tick;
  logic [NUM_CH-1:0]       frame_clk;
  logic [FRAME_W-1:0]      frame_cnt;

  frame_tick_gen #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .FRAME_W (FRAME_W),
    .EDGE_POL(0)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .VGA_VS    (VGA_VS),
    .ch_en     (ch_en),
    .div_i     (div_i),
    .frame_tick(frame_tick),
    .frame_clk (frame_clk),
    .frame_cnt (frame_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] cnt;
    logic [1:0] tick;
    logic [1:0] clk;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_cnt = '0;
  logic [3:0] last_cnt = '0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a frame_cnt change marks a detected edge; the tick follows one cycle later.
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset) begin
        last_cnt = '0;
      end else if (frame_cnt != last_cnt) begin
        last_cnt = frame_cnt;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_edge: frame_cnt=%0d with no pulse queued", frame_cnt);
        end else begin
          e = sb.pop_front();
          check("frame_cnt", 8'(frame_cnt), 8'(e.cnt));
          @(negedge Clk);
          check("frame_tick", 8'(frame_tick), 8'(e.tick));
          check("frame_clk", 8'(frame_clk), 8'(e.clk));
        end
      end else begin
        check("no_spurious_tick", 8'(frame_tick), 8'h00);
      end
    end
  end

  task automatic push_exp(input logic [1:0] t, input logic [1:0] c);
    exp_cnt = exp_cnt + 4'd1;
    sb.push_back({exp_cnt, t, c});
  endtask

  task automatic set_cfg(input logic [1:0] en, input logic [7:0] d0, input logic [7:0] d1);
    @(posedge Clk); #2;
    ch_en = en;
    div_i = {d1, d0};
  endtask

  task automatic pulse(input logic [1:0] t, input logic [1:0] c, input int hi);
    push_exp(t, c);
    @(posedge Clk); #2;
    VGA_VS = 1'b1;
    repeat (hi) @(posedge Clk);
    #2 VGA_VS = 1'b0;
    repeat (6) @(posedge Clk);
  endtask

  task automatic latency_pulse(input logic [1:0] t, input logic [1:0] c);
    int n;
    bit seen;
    push_exp(t, c);
    n = 0;
    seen = 0;
    @(posedge Clk); #2;
    VGA_VS = 1'b1;
    while (!seen && n < 12) begin
      @(posedge Clk); #1;
      n++;
      if (frame_tick != '0) seen = 1;
    end
    check("tick_latency", 8'(n), 8'(LAT));
    VGA_VS = 1'b0;
    repeat (6) @(posedge Clk);
  endtask

  task automatic do_reset();
    @(posedge Clk); #2;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    int n;
    // Reset with VS already high: nothing may fire after release.
    repeat (3) @(posedge Clk);
    #2;
    check("reset_tick", 8'(frame_tick), 8'h00);
    check("reset_clk", 8'(frame_clk), 8'h00);
    check("reset_cnt", 8'(frame_cnt), 8'h00);
    Reset = 1'b0;
    repeat (8) @(posedge Clk);
    #1 check("vs_high_at_release_cnt", 8'(frame_cnt), 8'h00);
    #1 VGA_VS = 1'b0;
    repeat (4) @(posedge Clk);

    // div=1 on ch0, varying pulse widths
    set_cfg(2'b01, 8'd1, 8'd0);
    latency_pulse(2'b01, 2'b01);
    pulse(2'b01, 2'b00, 3);
    pulse(2'b01, 2'b01, 1);
    pulse(2'b01, 2'b00, 5);
    pulse(2'b01, 2'b01, 2);
    #1 check("five_pulse_cnt", 8'(frame_cnt), 8'h05);
    check("five_pulse_clk", 8'(frame_clk), 8'h01);

    // ch0 div=2, ch1 div=3
    do_reset();
    set_cfg(2'b11, 8'd2, 8'd3);
    pulse(2'b00, 2'b00, 1);
    pulse(2'b01, 2'b01, 2);
    pulse(2'b10, 2'b11, 1);
    pulse(2'b01, 2'b10, 4);
    pulse(2'b00, 2'b10, 1);
    pulse(2'b11, 2'b01, 2);

    // divisor lowered mid-count fires on the next edge
    set_cfg(2'b01, 8'd5, 8'd3);
    pulse(2'b00, 2'b01, 1);
    pulse(2'b00, 2'b01, 1);
    pulse(2'b00, 2'b01, 1);
    set_cfg(2'b01, 8'd2, 8'd3);
    pulse(2'b01, 2'b00, 1);
    pulse(2'b00, 2'b00, 1);
    pulse(2'b01, 2'b01, 1);

    // div=0 acts as 1; disabled channels still advance frame_cnt
    set_cfg(2'b01, 8'd0, 8'd3);
    pulse(2'b01, 2'b00, 1);
    pulse(2'b01, 2'b01, 1);
    set_cfg(2'b00, 8'd0, 8'd3);
    pulse(2'b00, 2'b01, 1);
    pulse(2'b00, 2'b01, 2);
    pulse(2'b00, 2'b01, 1);
    #1 check("wrap_cnt_17", 8'(frame_cnt), 8'h01);

    // async reset mid-count
    set_cfg(2'b01, 8'd1, 8'd0);
    pulse(2'b01, 2'b00, 1);
    pulse(2'b01, 2'b01, 1);
    @(posedge Clk); #2;
    Reset = 1'b1;
    #1;
    check("async_rst_tick", 8'(frame_tick), 8'h00);
    check("async_rst_clk", 8'(frame_clk), 8'h00);
    check("async_rst_cnt", 8'(frame_cnt), 8'h00);
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;
    exp_cnt = '0;
    repeat (4) @(posedge Clk);
    pulse(2'b01, 2'b01, 1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge Clk);
      n++;
    end
    check("scoreboard_drained", 8'(sb.size()), 8'h00);
    repeat (4) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
